divider: RTL and testbench

Iterative 64-bit integer divider for the Execute stage. It consumes `div_start` and `div_mode` from Decode and returns `divider_done`, which Decode's control uses to release its stall. It implements UDIV and SDIV with one restoring-division step per cycle. Quotient and remainder are registered and held until the next accepted operation.

---
 rtl/divider_pkg.sv | 18 +
 rtl/div_step.sv | 29 ++
 rtl/divider.sv | 121 ++++++++++++
 tb/tb_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared width, state encodings and mode codes for the divider
package divider_pkg;

    // Native datapath word of the Execute stage
    localparam int WORD = 64;

    // Divider sequencing states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Operation selector shared with Decode control
    localparam logic DIV_MODE_UNSIGNED = 1'b0;
    localparam logic DIV_MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on {P, Q}
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [2*WIDTH:0]   i_pq,
    input  logic [WIDTH-1:0]   i_d,
    output logic [2*WIDTH:0]   o_pq
);

    // One guard bit above the shifted P keeps the trial subtraction sign unambiguous
    logic [WIDTH+1:0] w_p_sh;
    logic [WIDTH+1:0] w_t;
    logic [WIDTH-1:0] w_q_sh;

    assign w_p_sh = {i_pq[2*WIDTH:WIDTH], i_pq[WIDTH-1]};
    assign w_q_sh = {i_pq[WIDTH-2:0], 1'b0};
    assign w_t    = w_p_sh - {2'b00, i_d};

    // Restore P when the trial difference is negative, otherwise commit it and set the quotient bit
    always_comb begin
        o_pq = '0;
        if (w_t[WIDTH+1]) begin
            o_pq = {w_p_sh[WIDTH:0], w_q_sh};
        end else begin
            o_pq = {w_t[WIDTH:0], w_q_sh[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - iterative UDIV/SDIV unit, one quotient bit per cycle
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);

    div_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     r_p;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_done;
    logic               r_busy;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH:0]   w_pq_next;
    logic [WIDTH:0]     w_p_next;
    logic [WIDTH-1:0]   w_q_next;

    // Signed operands are divided as magnitudes; MIN stays MIN, which yields the wrapped MIN / -1 result
    assign w_a_neg = (i_mode == DIV_MODE_SIGNED) && i_dividend[WIDTH-1];
    assign w_b_neg = (i_mode == DIV_MODE_SIGNED) && i_divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_mag = w_b_neg ? -i_divisor  : i_divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_pq (({r_p, r_q})),
        .i_d  (r_d),
        .o_pq (w_pq_next)
    );

    assign w_p_next = w_pq_next[2*WIDTH:WIDTH];
    assign w_q_next = w_pq_next[WIDTH-1:0];

    // Sequencer: accept, iterate WIDTH steps, sign-fix into the held result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= DIV_IDLE;
            r_cnt       <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_q     <= w_a_mag;
                        r_d     <= w_b_mag;
                        r_p     <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_busy  <= 1'b1;
                        if (i_divisor == '0) begin
                            // Divide by zero: quotient 0, remainder is the raw dividend in either mode
                            r_state     <= DIV_DONE;
                            r_quotient  <= '0;
                            r_remainder <= i_dividend;
                            r_done      <= 1'b1;
                        end else begin
                            r_state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state     <= DIV_DONE;
                        r_done      <= 1'b1;
                        r_quotient  <= r_neg_q ? -w_q_next : w_q_next;
                        r_remainder <= r_neg_r ? -w_p_next[WIDTH-1:0] : w_p_next[WIDTH-1:0];
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_done      = r_done;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for the iterative divider
module tb_divider;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic        i_mode;
    logic [63:0] i_dividend;
    logic [63:0] i_divisor;
    logic [63:0] o_quotient;
    logic [63:0] o_remainder;
    logic        o_done;
    logic        o_busy;

    divider dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_done      (o_done),
        .o_busy      (o_busy)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          cyc;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: truncating division on magnitudes, ARMv8 divide-by-zero
    function automatic logic [127:0] model(input logic m, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ma, mb, q, r;
        logic nq, nr;
        if (b == 64'd0) return {64'd0, a};
        nq = m & (a[63] ^ b[63]);
        nr = m & a[63];
        ma = (m & a[63]) ? (~a + 64'd1) : a;
        mb = (m & b[63]) ? (~b + 64'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        return {nq ? (~q + 64'd1) : q, nr ? (~r + 64'd1) : r};
    endfunction

    task automatic start_op(input logic m, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] eq, input logic [63:0] er);
        exp_t e;
        @(negedge i_clk);
        i_start    = 1'b1;
        i_mode     = m;
        i_dividend = a;
        i_divisor  = b;
        e.q    = eq;
        e.r    = er;
        e.cyc  = cyc + 1 + ((b == 64'd0) ? 0 : 64);
        e.busy = (b == 64'd0) ? 1 : 65;
        sb.push_back(e);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (sb.size() == 0 && !o_busy) break;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_model(input logic m, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x;
        x = model(m, a, b);
        start_op(m, a, b, x[127:64], x[63:0]);
        drain();
    endtask

    // Output monitor: pops the scoreboard on every done pulse
    always @(negedge i_clk) begin
        exp_t e;
        if (i_reset) busy_cnt = 0;
        else if (o_busy) busy_cnt = busy_cnt + 1;
        if (o_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", o_quotient, e.q);
                check("remainder", o_remainder, e.r);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
            end
            busy_cnt = 0;
        end
    end

    initial begin
        logic [63:0] ra, rb;
        logic        rm;
        i_reset    = 1'b1;
        i_start    = 1'b1;
        i_mode     = 1'b0;
        i_dividend = 64'd9;
        i_divisor  = 64'd3;
        repeat (3) @(negedge i_clk);
        check("rst_quotient", o_quotient, 64'd0);
        check("rst_remainder", o_remainder, 64'd0);
        check("rst_done", {63'd0, o_done}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        i_start = 1'b0;
        i_reset = 1'b0;
        @(negedge i_clk);

        start_op(1'b0, 64'd100, 64'd7, 64'd14, 64'd2);                              drain();
        start_op(1'b1, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, -64'sd2);          drain();
        start_op(1'b1, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2);            drain();
        start_op(1'b1, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 64'd0); drain();
        start_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0); drain();
        start_op(1'b0, 64'd42, 64'd0, 64'd0, 64'd42);                                drain();
        start_op(1'b1, -64'sd5, 64'd0, 64'd0, -64'sd5);                              drain();
        start_op(1'b0, 64'd7, 64'd7, 64'd1, 64'd0);                                  drain();
        start_op(1'b0, 64'd3, 64'd10, 64'd0, 64'd3);                                 drain();

        // Re-pulsed start with fresh operands mid-RUN must be ignored
        start_op(1'b0, 64'd1000, 64'd3, 64'd333, 64'd1);
        repeat (10) @(negedge i_clk);
        i_start    = 1'b1;
        i_mode     = 1'b1;
        i_dividend = 64'd77;
        i_divisor  = 64'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        drain();

        for (int k = 0; k < 6; k++) begin
            ra = {$urandom, $urandom};
            rb = (k < 3) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom} >> $urandom_range(0, 60);
            if (rb == 64'd0) rb = 64'd1;
            rm = 1'($urandom_range(0, 1));
            if (k == 4) rb = -rb;
            run_model(rm, ra, rb);
        end

        // Reset at cycle 30 of RUN aborts with no done pulse
        start_op(1'b0, 64'd12345, 64'd17, 64'd0, 64'd0);
        repeat (29) @(negedge i_clk);
        i_reset = 1'b1;
        sb.delete();
        @(negedge i_clk);
        i_reset = 1'b0;
        check("abort_busy", {63'd0, o_busy}, 64'd0);
        check("abort_done", {63'd0, o_done}, 64'd0);
        check("abort_quotient", o_quotient, 64'd0);
        check("abort_remainder", o_remainder, 64'd0);
        repeat (80) @(negedge i_clk);
        check("abort_idle", {63'd0, o_busy}, 64'd0);

        start_op(1'b0, 64'd12345, 64'd17, 64'd726, 64'd3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
